spi_master_burst: RTL and testbench

Parametrised SPI master with a register front end, a DEPTH-word in-place TX/RX buffer, all four CPOL/CPHA modes, a programmable SCLK divider and N_SS active-low slave selects. One "send" command runs a burst of 1..DEPTH words with SS held low throughout. Received words overwrite their transmitted counterparts. Sits between the switch/LED register front end and the off-chip SPI pins.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_clk_gen.sv | 42 ++++
 rtl/spi_master_burst.sv | 219 +++++++++++++++++++++
 tb/tb_spi_master_burst.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and control-register layout for the burst SPI master.
package spi_pkg;

  localparam int CTRL_W       = 32;
  localparam int CTRL_SEND    = 0;
  localparam int CTRL_CPOL    = 1;
  localparam int CTRL_CPHA    = 2;
  localparam int CTRL_ERR     = 3;
  localparam int CTRL_SS_LSB  = 4;
  localparam int CTRL_SS_W    = 4;
  localparam int CTRL_NW_LSB  = 8;
  localparam int CTRL_NW_W    = 8;
  localparam int CTRL_DIV_LSB = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer and SCLK generator. The counter runs while en is high
// and raises tick on the last cycle of every half period; SCLK only toggles
// while run is high, otherwise it sits at the idle level cpol.
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             run,
  input  logic             cpol,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             tick,
  output logic             lead_edge,
  output logic             trail_edge
);

  logic [DIV_W-1:0] cnt;

  // cnt counts up from 0 and compares against the live div value, so a
  // divider written in the same cycle as send is honoured from the first
  // SETUP cycle onward.
  assign tick       = en && (cnt == div);
  assign lead_edge  = tick && run && (sclk == cpol);
  assign trail_edge = tick && run && (sclk != cpol);

  // Half-period counter and SCLK level register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= cpol;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick && run) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master_burst.sv
// Burst SPI master: register front end, in-place TX/RX word buffer and a
// four-state sequencer driving one of N_SS active-low slave selects.
//
//   state | meaning
//   IDLE  | SS all high, SCLK at cpol, host may write buffer/control
//   SETUP | SS low, word 0 loaded, one half period before the first edge
//   XFER  | 2*DATA_W edges per word, nwords words back-to-back
//   HOLD  | SS still low for one half period after the last edge
module spi_master_burst
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int N_SS   = 2,
  parameter int DIV_W  = 8
) (
  input  logic                     clk_pi,
  input  logic                     rst_n_pi,
  input  logic                     wr_pi,
  input  logic                     reg_sel_pi,
  input  logic [$clog2(DEPTH)-1:0] addr_pi,
  input  logic [31:0]              wdata_pi,
  output logic [31:0]              rdata_po,
  output logic                     busy_po,
  output logic                     done_po,
  input  logic                     miso_pi,
  output logic                     mosi_po,
  output logic                     sclk_po,
  output logic [N_SS-1:0]          ss_po
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W - 1);

  state_t state, state_n;

  mode_t                mode;
  logic [CTRL_SS_W-1:0] ss_sel;
  logic [CTRL_NW_W-1:0] nw_m1;
  logic [DIV_W-1:0]     div;
  logic                 err;
  logic                 done_q;
  logic [CTRL_W-1:0]    rdata_q;
  logic [CTRL_W-1:0]    ctrl_rd;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] tx_sh, rx_sh, rx_next, word0, next_word;
  logic [AW-1:0]     word_idx;
  logic [EW-1:0]     edge_cnt;
  logic              mosi_q;

  logic busy, ctrl_wr, buf_wr, ss_ok, send_ok, send_bad, cpol_nxt;
  logic tick, lead_edge, trail_edge, sclk;
  logic any_edge, shift_edge, sample_edge, word_end, last_word;
  logic unused_wdata;

  assign busy     = (state != IDLE);
  assign ctrl_wr  = wr_pi && reg_sel_pi && !busy;
  assign buf_wr   = wr_pi && !reg_sel_pi && !busy;
  assign ss_ok    = int'(wdata_pi[CTRL_SS_LSB +: CTRL_SS_W]) < N_SS;
  assign send_ok  = ctrl_wr && wdata_pi[CTRL_SEND] && ss_ok;
  assign send_bad = ctrl_wr && wdata_pi[CTRL_SEND] && !ss_ok;
  assign unused_wdata = ^wdata_pi;

  // Idle SCLK follows the cpol being written this cycle, so SETUP already
  // starts at the new idle level.
  assign cpol_nxt = ctrl_wr ? wdata_pi[CTRL_CPOL] : mode.cpol;

  assign any_edge    = lead_edge || trail_edge;
  assign shift_edge  = mode.cpha ? lead_edge : trail_edge;
  assign sample_edge = mode.cpha ? trail_edge : lead_edge;
  assign word_end    = trail_edge && (edge_cnt == EDGE_LAST);
  assign last_word   = (word_idx == nw_m1[AW-1:0]);
  assign rx_next     = {rx_sh[DATA_W-2:0], miso_pi};
  assign word0       = mem[0];
  assign next_word   = mem[word_idx + 1'b1];

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk        (clk_pi),
    .rst_n      (rst_n_pi),
    .en         (busy),
    .run        (state == XFER),
    .cpol       (cpol_nxt),
    .div        (div),
    .sclk       (sclk),
    .tick       (tick),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge)
  );

  // State register.
  always_ff @(posedge clk_pi) begin
    if (!rst_n_pi) state <= IDLE;
    else           state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (send_ok) state_n = SETUP;
      SETUP:   if (tick) state_n = XFER;
      XFER:    if (word_end && last_word) state_n = HOLD;
      HOLD:    if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control register readback image; send reads back as busy.
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_SEND] = busy;
    ctrl_rd[CTRL_CPOL] = mode.cpol;
    ctrl_rd[CTRL_CPHA] = mode.cpha;
    ctrl_rd[CTRL_ERR]  = err;
    ctrl_rd[CTRL_SS_LSB +: CTRL_SS_W]  = ss_sel;
    ctrl_rd[CTRL_NW_LSB +: CTRL_NW_W]  = nw_m1;
    ctrl_rd[CTRL_DIV_LSB +: DIV_W]     = div;
  end

  // Control fields, sticky error, done pulse and registered read port.
  always_ff @(posedge clk_pi) begin
    if (!rst_n_pi) begin
      mode    <= '0;
      ss_sel  <= '0;
      nw_m1   <= '0;
      div     <= '0;
      err     <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= (state == HOLD) && tick;
      if (wr_pi && busy) begin
        err <= 1'b1;
      end else if (ctrl_wr) begin
        mode.cpol <= wdata_pi[CTRL_CPOL];
        mode.cpha <= wdata_pi[CTRL_CPHA];
        ss_sel    <= wdata_pi[CTRL_SS_LSB +: CTRL_SS_W];
        nw_m1     <= wdata_pi[CTRL_NW_LSB +: CTRL_NW_W];
        div       <= wdata_pi[CTRL_DIV_LSB +: DIV_W];
        err       <= send_bad;
      end
      rdata_q <= reg_sel_pi ? ctrl_rd : CTRL_W'(mem[addr_pi]);
    end
  end

  // Word buffer: host writes while idle, received words replace sent ones.
  always_ff @(posedge clk_pi) begin
    if (rst_n_pi) begin
      if (buf_wr)
        mem[addr_pi] <= wdata_pi[DATA_W-1:0];
      else if ((state == XFER) && word_end)
        mem[word_idx] <= mode.cpha ? rx_next : rx_sh;
    end
  end

  // Shift datapath. For cpha=0 the MSB goes straight onto MOSI at load time;
  // for cpha=1 it appears on the first leading edge.
  always_ff @(posedge clk_pi) begin
    if (!rst_n_pi) begin
      tx_sh    <= '0;
      rx_sh    <= '0;
      word_idx <= '0;
      edge_cnt <= '0;
      mosi_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (send_ok) begin
            word_idx <= '0;
            edge_cnt <= '0;
            rx_sh    <= '0;
            if (wdata_pi[CTRL_CPHA]) begin
              tx_sh <= word0;
            end else begin
              mosi_q <= word0[DATA_W-1];
              tx_sh  <= word0 << 1;
            end
          end
        end
        XFER: begin
          if (word_end) begin
            edge_cnt <= '0;
            rx_sh    <= '0;
            if (!last_word) begin
              word_idx <= word_idx + 1'b1;
              if (mode.cpha) begin
                tx_sh <= next_word;
              end else begin
                mosi_q <= next_word[DATA_W-1];
                tx_sh  <= next_word << 1;
              end
            end
          end else begin
            if (any_edge) edge_cnt <= edge_cnt + 1'b1;
            if (sample_edge) rx_sh <= rx_next;
            if (shift_edge) begin
              mosi_q <= tx_sh[DATA_W-1];
              tx_sh  <= tx_sh << 1;
            end
          end
        end
        HOLD: begin
          if (tick) mosi_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rdata_po = rdata_q;
  assign busy_po  = busy;
  assign done_po  = done_q;
  assign mosi_po  = mosi_q;
  assign sclk_po  = sclk;
  assign ss_po    = busy ? ~(N_SS'(1) << ss_sel) : '1;

endmodule

// File: tb/tb_spi_master_burst.sv
// Directed plus randomized bench for spi_master_burst with an SPI slave model
// that works from sclk/ss edges, and burst-level expectations from the
// timing formula h*(2 + 2*DATA_W*nwords).
module tb_spi_master_burst;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int N_SS   = 2;
  localparam int DIV_W  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic        reg_sel = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy, done, miso, mosi, sclk;
  logic [N_SS-1:0] ss;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master_burst #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .N_SS(N_SS), .DIV_W(DIV_W)
  ) dut (
    .clk_pi     (clk),
    .rst_n_pi   (rst_n),
    .wr_pi      (wr),
    .reg_sel_pi (reg_sel),
    .addr_pi    (addr),
    .wdata_pi   (wdata),
    .rdata_po   (rdata),
    .busy_po    (busy),
    .done_po    (done),
    .miso_pi    (miso),
    .mosi_po    (mosi),
    .sclk_po    (sclk),
    .ss_po      (ss)
  );

  // slave_kind: 0 = slave model, 1 = loopback, 2 = constant 1
  int         slave_kind = 0;
  logic       miso_slv = 1'b0;
  bit         tb_cpol, tb_cpha;
  logic [7:0] slv_q[$];
  logic [7:0] got_q[$];
  logic [7:0] slv_cur, got_sh;
  int         slv_bi, slv_ec, got_n;
  logic       ss_prev_act = 1'b0;
  logic       sclk_prev = 1'b0;
  logic [1:0] ss_exp;

  int cyc = 0, busy_cyc, ss_low_cyc, ss_bad, done_cnt, edges, rises;
  int mosi_hi, min_iv, max_iv, last_chg;
  bit have_chg;

  assign miso = (slave_kind == 1) ? mosi : ((slave_kind == 2) ? 1'b1 : miso_slv);

  // Slave model and burst statistics, evaluated away from the active edge.
  always @(negedge clk) begin
    logic ss_act, lead;
    cyc++;
    ss_act = (ss != 2'b11);
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (ss_act) begin
      ss_low_cyc++;
      if (ss != ss_exp) ss_bad++;
      if (mosi) mosi_hi++;
    end
    if (ss_act && !ss_prev_act) begin
      slv_ec = 0;
      got_n  = 0;
      slv_cur = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
      if (!tb_cpha) begin miso_slv = slv_cur[7]; slv_bi = 1; end
      else slv_bi = 0;
    end else if (ss_act && (sclk != sclk_prev)) begin
      lead = (sclk_prev == tb_cpol);
      edges++;
      if (sclk) rises++;
      if (have_chg) begin
        if (cyc - last_chg < min_iv) min_iv = cyc - last_chg;
        if (cyc - last_chg > max_iv) max_iv = cyc - last_chg;
      end
      last_chg = cyc;
      have_chg = 1;
      if (lead != tb_cpha) begin
        got_sh = {got_sh[6:0], mosi};
        got_n++;
        if (got_n == 8) begin got_q.push_back(got_sh); got_n = 0; end
      end
      slv_ec++;
      if (slv_ec == 16) begin
        slv_ec = 0;
        slv_cur = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
        if (!tb_cpha) begin miso_slv = slv_cur[7]; slv_bi = 1; end
        else slv_bi = 0;
      end else if (lead == tb_cpha) begin
        miso_slv = slv_cur[7 - slv_bi];
        slv_bi++;
      end
    end
    ss_prev_act = ss_act;
    sclk_prev   = sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic sel, input logic [1:0] a, input logic [31:0] d);
    wr = 1'b1; reg_sel = sel; addr = a; wdata = d;
    step();
    wr = 1'b0;
  endtask

  task automatic read(input logic sel, input logic [1:0] a, output logic [31:0] d);
    reg_sel = sel; addr = a;
    step();
    d = rdata;
  endtask

  function automatic logic [31:0] mk_ctrl(bit b0, bit cpol, bit cpha, bit err,
                                          logic [3:0] ssel, logic [7:0] nwm1,
                                          logic [7:0] dv);
    return {8'h00, dv, nwm1, ssel, err, cpha, cpol, b0};
  endfunction

  task automatic clr_stats();
    busy_cyc = 0; ss_low_cyc = 0; ss_bad = 0; done_cnt = 0; edges = 0;
    rises = 0; mosi_hi = 0; min_iv = 1 << 20; max_iv = 0; have_chg = 0;
  endtask

  bit         cur_cpol, cur_cpha;
  logic [3:0] cur_ss;
  int         cur_n, cur_div;
  logic [7:0] tx_w[4];
  logic [7:0] rx_w[4];

  task automatic start_burst(input bit cpol, input bit cpha, input int ssel,
                             input int n, input int dv, input int kind);
    cur_cpol = cpol; cur_cpha = cpha; cur_ss = 4'(ssel); cur_n = n; cur_div = dv;
    for (int i = 0; i < n; i++) write(1'b0, 2'(i), {24'h0, tx_w[i]});
    slv_q.delete();
    got_q.delete();
    for (int i = 0; i < n; i++) slv_q.push_back(rx_w[i]);
    tb_cpol = cpol; tb_cpha = cpha; slave_kind = kind;
    ss_exp = ~(2'b01 << ssel);
    clr_stats();
    write(1'b1, 2'd0, mk_ctrl(1, cpol, cpha, 0, cur_ss, 8'(n - 1), 8'(dv)));
    check("busy_rise", {31'h0, busy}, 32'd1);
  endtask

  task automatic finish_burst(input bit err_exp);
    int h, dur, k;
    bit seen;
    logic [31:0] d;
    h   = cur_div + 1;
    dur = h * (2 + 2 * DATA_W * cur_n);
    k = 0; seen = 0;
    while (k < dur + 40 && !seen) begin
      @(negedge clk);
      if (done) seen = 1;
      k++;
    end
    check("done_seen", {31'h0, seen}, 32'd1);
    step(); step(); step();
    check("busy_cycles", busy_cyc, dur);
    check("ss_low_cycles", ss_low_cyc, dur);
    check("ss_wrong_line", ss_bad, 0);
    check("done_pulses", done_cnt, 1);
    check("sclk_edges", edges, 2 * DATA_W * cur_n);
    check("sclk_rises", rises, DATA_W * cur_n);
    check("half_period_min", min_iv, h);
    check("half_period_max", max_iv, h);
    check("sclk_idle", {31'h0, sclk}, {31'h0, cur_cpol});
    check("tx_word_count", got_q.size(), cur_n);
    for (int i = 0; i < cur_n && i < got_q.size(); i++)
      check("tx_word", {24'h0, got_q[i]}, {24'h0, tx_w[i]});
    for (int i = 0; i < cur_n; i++) begin
      read(1'b0, 2'(i), d);
      check("rx_word", d, {24'h0, rx_w[i]});
    end
    read(1'b1, 2'd0, d);
    check("ctrl_after", d, mk_ctrl(0, cur_cpol, cur_cpha, err_exp, cur_ss,
                                   8'(cur_n - 1), 8'(cur_div)));
  endtask

  initial begin
    logic [31:0] d;
    int k;

    // Reset values
    step(); step();
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_done", {31'h0, done}, 0);
    check("rst_mosi", {31'h0, mosi}, 0);
    check("rst_sclk", {31'h0, sclk}, 0);
    check("rst_ss", {30'h0, ss}, 32'h3);
    check("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    step();
    read(1'b1, 2'd0, d);
    check("rst_ctrl", d, 0);

    // Loopback, mode 0, div 1, ss 1, two words
    tx_w[0] = 8'hA5; tx_w[1] = 8'h3C;
    rx_w[0] = 8'hA5; rx_w[1] = 8'h3C;
    start_burst(0, 0, 1, 2, 1, 1);
    finish_burst(0);

    // Mode 3, div 0, miso tied high, one zero word
    write(1'b1, 2'd0, mk_ctrl(0, 1, 1, 0, 4'd0, 8'd0, 8'd0));
    step();
    check("cpol1_idle", {31'h0, sclk}, 32'd1);
    tx_w[0] = 8'h00; rx_w[0] = 8'hFF;
    start_burst(1, 1, 0, 1, 0, 2);
    finish_burst(0);
    check("mode3_mosi_low", mosi_hi, 0);

    // Mode 1, slave returns 0x5A, div 3
    tx_w[0] = 8'($urandom); rx_w[0] = 8'h5A;
    start_burst(0, 1, 0, 1, 3, 0);
    finish_burst(0);

    // Writes during a burst are ignored and set err
    for (int i = 0; i < 4; i++) begin tx_w[i] = 8'($urandom); rx_w[i] = 8'($urandom); end
    start_burst(1, 0, 1, 4, 2, 0);
    step(); step(); step(); step();
    write(1'b0, 2'd2, 32'hEE);
    write(1'b1, 2'd0, mk_ctrl(1, 0, 1, 0, 4'd0, 8'd0, 8'd5));
    read(1'b1, 2'd0, d);
    check("err_while_busy", d, mk_ctrl(1, 1, 0, 1, 4'd1, 8'd3, 8'd2));
    finish_burst(1);
    write(1'b1, 2'd0, mk_ctrl(0, 1, 0, 0, 4'd1, 8'd3, 8'd2));
    read(1'b1, 2'd0, d);
    check("err_cleared", d, mk_ctrl(0, 1, 0, 0, 4'd1, 8'd3, 8'd2));

    // Send with an out-of-range slave select
    write(1'b1, 2'd0, mk_ctrl(1, 0, 0, 0, 4'd3, 8'd0, 8'd1));
    for (int i = 0; i < 3; i++) begin
      check("bad_ss_busy", {31'h0, busy}, 0);
      check("bad_ss_lines", {30'h0, ss}, 32'h3);
      step();
    end
    read(1'b1, 2'd0, d);
    check("bad_ss_ctrl", d, mk_ctrl(0, 0, 0, 1, 4'd3, 8'd0, 8'd1));

    // Reset in word 1, around bit 3, mode 3
    for (int i = 0; i < 2; i++) begin tx_w[i] = 8'($urandom); rx_w[i] = 8'($urandom); end
    start_burst(1, 1, 0, 2, 1, 0);
    k = 0;
    while (edges < 25 && k < 500) begin @(negedge clk); k++; end
    check("reach_word1", {31'h0, edges >= 25}, 32'd1);
    rst_n = 1'b0;
    done_cnt = 0;
    step();
    check("abort_busy", {31'h0, busy}, 0);
    check("abort_ss", {30'h0, ss}, 32'h3);
    check("abort_sclk", {31'h0, sclk}, 0);
    check("abort_mosi", {31'h0, mosi}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("abort_no_done", done_cnt, 0);
    read(1'b1, 2'd0, d);
    check("abort_ctrl", d, 0);
    read(1'b0, 2'd0, d);
    check("abort_word0_kept", d, {24'h0, rx_w[0]});

    // Randomized bursts
    for (int t = 0; t < 8; t++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) begin tx_w[i] = 8'($urandom); rx_w[i] = 8'($urandom); end
      start_burst(1'($urandom), 1'($urandom), int'($urandom_range(0, 1)), n,
                  int'($urandom_range(0, 3)), 0);
      finish_burst(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
